led_matrix_scan: RTL and testbench
==================================

Name: led_matrix_scan

Overview:
- Downstream display stage of the Game of Life top level.
- Consumes the 64-bit 8x8 GridOut generation word and drives a multiplexed 8x8 LED matrix one row at a time.
- Double-buffers the grid so a new generation is shown only at a frame boundary, which prevents tearing.
- Inserts a configurable blanking interval between rows to suppress ghosting.

Parameters:
- DWELL_CYCLES, 1000: clocks each row is driven; legal range 1..65535.
- BLANK_CYCLES, 2: clocks with all outputs off before each row; 0 means no blanking; legal range 0..255.
- ROW_ACTIVE_LOW, 1: 1 means a selected row is driven 0.
- COL_ACTIVE_LOW, 0: 1 means a lit column is driven 0.

Ports:
- clk  in  1: system clock.
- reset_n  in  1: asynchronous, active-low reset.
- grid_in  in  64: current generation; row r = grid_in[8r+7:8r]; bit c of a row drives column c.
- grid_valid  in  1: when high at a rising edge, grid_in is captured into the shadow register.
- enable  in  1: scan enable; low blanks the display.
- row_sel  out  8: one-hot row drive, polarity set by ROW_ACTIVE_LOW.
- col_data  out  8: column drive for the active row, polarity set by COL_ACTIVE_LOW.
- frame_start  out  1: one-cycle pulse when the display buffer reloads.
- row_idx  out  3: index of the row currently being scanned.

Behaviour:
- All outputs are registered.
- "Off" level:
  - row_sel = all inactive: 8'hFF if ROW_ACTIVE_LOW, else 8'h00.
  - col_data = all dark: 8'hFF if COL_ACTIVE_LOW, else 8'h00.
- Reset (async assert, sync release):
  - State = IDLE; shadow = 0; display buffer = 0; row_idx = 0.
  - Dwell counter = 0; frame_start = 0; row_sel and col_data at Off.
- Shadow register:
  - Captures grid_in on every edge where grid_valid = 1, in any state.
  - The last capture before a LOAD wins.
  - If grid_valid is high in the same cycle the FSM is in LOAD, that capture lands in the shadow and appears in the next frame, not the current one.
- FSM states:
  - IDLE: outputs Off; enable = 1 -> LOAD.
  - LOAD (exactly 1 cycle):
    - display buffer <= shadow; row_idx <= 0; frame_start = 1 for this cycle only; outputs Off.
    - -> BLANK if BLANK_CYCLES > 0, else -> DRIVE.
  - BLANK: outputs Off for BLANK_CYCLES cycles -> DRIVE.
  - DRIVE:
    - row_sel active on bit row_idx only; col_data = display buffer row row_idx, with polarity applied.
    - Lasts DWELL_CYCLES cycles.
    - At the end: if row_idx = 7, go to LOAD (wrap; row_idx returns to 0 in LOAD).
    - Otherwise row_idx increments and the FSM goes to BLANK, or directly to DRIVE if BLANK_CYCLES = 0.
- Frame period = 1 + 8*(BLANK_CYCLES + DWELL_CYCLES) cycles. frame_start pulses once per period.
- enable deasserted in any non-IDLE state:
  - The next cycle is IDLE with outputs Off and row_idx = 0.
  - The display buffer is retained.
  - Re-enabling always restarts at LOAD; a scan never resumes mid-frame.
- Dwell/blank counter: 16 bits, reloaded on every state entry. No off-by-one: a DRIVE with DWELL_CYCLES = 1 shows the row for exactly 1 cycle.
- At most one row_sel bit is active in any cycle. Glitch-free transitions: DRIVE row N -> row N+1 with BLANK_CYCLES = 0 changes row_sel and col_data on the same edge.
- Reset asserted mid-frame: outputs go to Off immediately (asynchronously), and all state clears as in Reset.

Test Plan:
1. Reset, then release with enable = 1, DWELL = 4, BLANK = 1, after a grid_valid capture of 64'h8040201008040201.
   - Required: frame_start high on cycle 1 after release.
   - Row 0 driven with col_data = 8'h01 and row_sel = 8'hFE for 4 cycles after 1 blank cycle.
   - Row 7 shows col_data = 8'h80.
   - frame_start recurs every 41 cycles.
2. Anti-tearing: mid-frame (during row 3), capture 64'hFFFFFFFFFFFFFFFF.
   - Required: rows 3..7 still show the old pattern.
   - The next frame shows col_data = 8'hFF on all rows.
3. Same-cycle collision: grid_valid pulsed exactly in the LOAD cycle with 64'h00000000000000AA.
   - Required: the current frame shows the prior shadow.
   - The following frame's row 0 shows 8'hAA.
4. enable dropped during row 5 DRIVE.
   - Required: next cycle row_sel = 8'hFF, col_data = 8'h00, row_idx = 0.
   - Re-enable: frame_start on the first cycle, and the scan begins at row 0.
5. BLANK = 0, DWELL = 1.
   - Required: frame period 9 cycles; row_idx steps 0..7 on consecutive cycles.
   - row_sel is never zero-active in DRIVE; always exactly one bit active after the LOAD cycle.
6. reset_n asserted mid-row 4 with a non-zero buffer.
   - Required: outputs go Off without waiting for a clock edge.
   - After release with enable = 1 and no capture, all rows show col_data = 8'h00.

Source files
------------

// File: rtl/led_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module   : led_matrix_scan
// Purpose  : Multiplexed 8x8 LED matrix driver for the Game of Life grid.
//            A shadow register collects generations as they arrive. A
//            display buffer reloads from the shadow only at a frame
//            boundary, so a frame never mixes two generations. An optional
//            blanking gap before each row suppresses ghosting.
// Ports    : clk         - system clock
//            reset_n     - asynchronous active-low reset
//            grid_in     - 64-bit generation, row r = grid_in[8r+7:8r]
//            grid_valid  - capture strobe for grid_in into the shadow
//            enable      - scan enable; low blanks the display
//            row_sel     - one-hot row drive (polarity ROW_ACTIVE_LOW)
//            col_data    - column drive for active row (polarity COL_ACTIVE_LOW)
//            frame_start - one-cycle pulse in the buffer reload cycle
//            row_idx     - row currently being scanned
// Revision : 1.0 - initial release
// ============================================================================
module led_matrix_scan #(
  parameter int DWELL_CYCLES   = 1000,
  parameter int BLANK_CYCLES   = 2,
  parameter bit ROW_ACTIVE_LOW = 1'b1,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] grid_in,
  input  logic        grid_valid,
  input  logic        enable,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        frame_start,
  output logic [2:0]  row_idx
);

  localparam logic [7:0]  c_row_off      = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]  c_col_off      = COL_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam bit          c_has_blank    = (BLANK_CYCLES > 0);
  // The counter is loaded with (length - 1) on state entry and the state is
  // left when it reads zero, so a length of N occupies exactly N cycles.
  localparam logic [15:0] c_dwell_reload = 16'(DWELL_CYCLES - 1);
  localparam logic [15:0] c_blank_reload = c_has_blank ? 16'(BLANK_CYCLES - 1) : 16'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_BLANK = 2'd2,
    S_DRIVE = 2'd3
  } state_t;

  state_t      r_state;
  logic [63:0] r_shadow;
  logic [63:0] r_display;
  logic [15:0] r_cnt;

  logic [2:0]  w_src_row;
  logic [63:0] w_src_buf;
  logic [7:0]  w_row_onehot;
  logic [7:0]  w_row_bits;
  logic [7:0]  w_drive_row_sel;
  logic [7:0]  w_drive_col;

  // Row and pattern that will be shown if the FSM enters DRIVE on this edge.
  // Leaving LOAD, the display buffer is being written on the same edge, so
  // the pattern is taken straight from the shadow. Leaving DRIVE directly
  // (no blanking), the next row is used so row and columns switch together.
  always_comb begin
    w_src_row = row_idx;
    w_src_buf = r_display;
    case (r_state)
      S_LOAD: begin
        w_src_row = 3'd0;
        w_src_buf = r_shadow;
      end
      S_DRIVE: w_src_row = row_idx + 3'd1;
      default: ;
    endcase
    w_row_onehot    = 8'b0000_0001 << w_src_row;
    w_row_bits      = w_src_buf[{w_src_row, 3'b000} +: 8];
    w_drive_row_sel = ROW_ACTIVE_LOW ? ~w_row_onehot : w_row_onehot;
    w_drive_col     = COL_ACTIVE_LOW ? ~w_row_bits : w_row_bits;
  end

  // Shadow register: free-running capture, independent of the scan state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
    end else if (grid_valid) begin
      r_shadow <= grid_in;
    end
  end

  // Scan FSM. Outputs are registered alongside the state so they always
  // describe the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_display   <= '0;
      r_cnt       <= '0;
      row_idx     <= '0;
      frame_start <= 1'b0;
      row_sel     <= c_row_off;
      col_data    <= c_col_off;
    end else begin
      frame_start <= 1'b0;
      if (r_state != S_IDLE && !enable) begin
        // Abort the frame; the display buffer is kept, the next enable
        // always restarts with a fresh LOAD.
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        row_idx  <= '0;
        row_sel  <= c_row_off;
        col_data <= c_col_off;
      end else begin
        case (r_state)
          S_IDLE: begin
            row_sel  <= c_row_off;
            col_data <= c_col_off;
            if (enable) begin
              r_state     <= S_LOAD;
              r_cnt       <= '0;
              row_idx     <= '0;
              frame_start <= 1'b1;
            end
          end

          S_LOAD: begin
            r_display <= r_shadow;
            row_idx   <= '0;
            if (c_has_blank) begin
              r_state <= S_BLANK;
              r_cnt   <= c_blank_reload;
            end else begin
              r_state  <= S_DRIVE;
              r_cnt    <= c_dwell_reload;
              row_sel  <= w_drive_row_sel;
              col_data <= w_drive_col;
            end
          end

          S_BLANK: begin
            if (r_cnt == 16'd0) begin
              r_state  <= S_DRIVE;
              r_cnt    <= c_dwell_reload;
              row_sel  <= w_drive_row_sel;
              col_data <= w_drive_col;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end

          S_DRIVE: begin
            if (r_cnt == 16'd0) begin
              if (row_idx == 3'd7) begin
                r_state     <= S_LOAD;
                r_cnt       <= '0;
                row_idx     <= '0;
                frame_start <= 1'b1;
                row_sel     <= c_row_off;
                col_data    <= c_col_off;
              end else begin
                row_idx <= w_src_row;
                if (c_has_blank) begin
                  r_state  <= S_BLANK;
                  r_cnt    <= c_blank_reload;
                  row_sel  <= c_row_off;
                  col_data <= c_col_off;
                end else begin
                  r_state  <= S_DRIVE;
                  r_cnt    <= c_dwell_reload;
                  row_sel  <= w_drive_row_sel;
                  col_data <= w_drive_col;
                end
              end
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_matrix_scan
// Purpose  : Self-checking bench for led_matrix_scan. Two instances run side
//            by side: a slow one (DWELL 4, BLANK 1) and a fast one (DWELL 1,
//            BLANK 0). A frame-position model predicts every output from
//            the position inside the frame period.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_matrix_scan;

  localparam int D0 = 4;
  localparam int B0 = 1;
  localparam int D1 = 1;
  localparam int B1 = 0;
  localparam logic [19:0] OFF_IDLE = {8'hFF, 8'h00, 3'd0, 1'b0};

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [63:0] gi [2];
  logic        gv [2];
  logic        en [2];
  logic [7:0]  rs [2];
  logic [7:0]  cd [2];
  logic        fs [2];
  logic [2:0]  ri [2];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: active flag, position in frame (0 = reload cycle),
  // displayed grid and pending grid.
  bit          m_active [2];
  int          m_t      [2];
  logic [63:0] m_disp   [2];
  logic [63:0] m_shadow [2];

  always #5 clk = ~clk;

  led_matrix_scan #(.DWELL_CYCLES(D0), .BLANK_CYCLES(B0),
                    .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(0)) dut (
    .clk(clk), .reset_n(reset_n), .grid_in(gi[0]), .grid_valid(gv[0]),
    .enable(en[0]), .row_sel(rs[0]), .col_data(cd[0]),
    .frame_start(fs[0]), .row_idx(ri[0]));

  led_matrix_scan #(.DWELL_CYCLES(D1), .BLANK_CYCLES(B1),
                    .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(0)) dut_fast (
    .clk(clk), .reset_n(reset_n), .grid_in(gi[1]), .grid_valid(gv[1]),
    .enable(en[1]), .row_sel(rs[1]), .col_data(cd[1]),
    .frame_start(fs[1]), .row_idx(ri[1]));

  function automatic int slot(int i);
    return (i == 0) ? (B0 + D0) : (B1 + D1);
  endfunction

  function automatic int blank_len(int i);
    return (i == 0) ? B0 : B1;
  endfunction

  function automatic int period(int i);
    return 1 + 8 * slot(i);
  endfunction

  // Expected {row_sel, col_data, row_idx, frame_start}.
  function automatic logic [19:0] expect_out(int i);
    int k;
    int r;
    logic [7:0] one;
    if (!m_active[i]) return OFF_IDLE;
    if (m_t[i] == 0) return {8'hFF, 8'h00, 3'd0, 1'b1};
    k = m_t[i] - 1;
    r = k / slot(i);
    if ((k % slot(i)) < blank_len(i)) return {8'hFF, 8'h00, 3'(r), 1'b0};
    one = 8'h01 << r;
    return {~one, m_disp[i][8*r +: 8], 3'(r), 1'b0};
  endfunction

  function automatic logic [19:0] obs(int i);
    return {rs[i], cd[i], ri[i], fs[i]};
  endfunction

  // True in the first DRIVE cycle of the slow instance.
  function automatic bit first_drive0();
    return (m_t[0] > 0) && (((m_t[0] - 1) % slot(0)) == B0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0;
      m_t[i]      = 0;
      m_disp[i]   = '0;
      m_shadow[i] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_active[i] = 1'b0; m_t[i] = 0; m_disp[i] = '0; m_shadow[i] = '0;
      end else begin
        if (!m_active[i]) begin
          if (en[i]) begin m_active[i] = 1'b1; m_t[i] = 0; end
        end else if (!en[i]) begin
          m_active[i] = 1'b0;
        end else begin
          if (m_t[i] == 0) m_disp[i] = m_shadow[i];
          m_t[i] = (m_t[i] + 1) % period(i);
        end
        if (gv[i]) m_shadow[i] = gi[i];
      end
    end
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      gi[i] = '0; gv[i] = 1'b0; en[i] = 1'b0;
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs(i) !== OFF_IDLE) begin
        n_errors++; $display("FAIL reset_async[%0d]: got %h expected %h", i, obs(i), OFF_IDLE);
      end
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs(i) !== OFF_IDLE) begin
        n_errors++; $display("FAIL reset_held[%0d]: got %h expected %h", i, obs(i), OFF_IDLE);
      end
    end
  endtask

  task automatic test_scan_basic();
    reset_n = 1'b1;
    tick();
    gv[0] = 1'b1; gi[0] = 64'h8040201008040201;
    tick();
    gv[0] = 1'b0; en[0] = 1'b1;
    tick();
    n_checks++;
    if (fs[0] !== 1'b1) begin
      n_errors++; $display("FAIL first_frame_start: got %b expected 1", fs[0]);
    end
    for (int c = 1; c <= 41; c++) begin
      tick();
      n_checks++;
      if (obs(0) !== expect_out(0)) begin
        n_errors++; $display("FAIL basic_c%0d: got %h expected %h", c, obs(0), expect_out(0));
      end
      if (c == 1) begin
        n_checks++;
        if (rs[0] !== 8'hFF) begin
          n_errors++; $display("FAIL basic_blank: got %h expected ff", rs[0]);
        end
      end
      if (c >= 2 && c <= 5) begin
        n_checks++;
        if ({rs[0], cd[0]} !== {8'hFE, 8'h01}) begin
          n_errors++; $display("FAIL basic_row0_c%0d: got %h expected fe01", c, {rs[0], cd[0]});
        end
      end
      if (c >= 37 && c <= 40) begin
        n_checks++;
        if ({rs[0], cd[0], ri[0]} !== {8'h7F, 8'h80, 3'd7}) begin
          n_errors++; $display("FAIL basic_row7_c%0d: got %h expected %h", c, {rs[0], cd[0], ri[0]}, {8'h7F, 8'h80, 3'd7});
        end
      end
      if (c == 40 || c == 41) begin
        n_checks++;
        if (fs[0] !== (c == 41)) begin
          n_errors++; $display("FAIL frame_period_c%0d: got %b expected %b", c, fs[0], (c == 41));
        end
      end
    end
  endtask

  task automatic test_anti_tearing();
    for (int c = 0; c < 100 && m_t[0] != 17; c++) tick();
    n_checks++;
    if (m_t[0] != 17 || ri[0] !== 3'd3) begin
      n_errors++; $display("FAIL tear_reach_row3: got row %0d expected 3", ri[0]);
    end
    gv[0] = 1'b1; gi[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    gv[0] = 1'b0;
    for (int c = 0; c < 100 && m_t[0] != 0; c++) begin
      n_checks++;
      if (obs(0) !== expect_out(0)) begin
        n_errors++; $display("FAIL tear_model_t%0d: got %h expected %h", m_t[0], obs(0), expect_out(0));
      end
      if (first_drive0()) begin
        n_checks++;
        if (cd[0] !== (8'h01 << ri[0])) begin
          n_errors++; $display("FAIL tear_old_row%0d: got %h expected %h", ri[0], cd[0], 8'h01 << ri[0]);
        end
      end
      tick();
    end
    for (int c = 0; c < 41; c++) begin
      tick();
      n_checks++;
      if (obs(0) !== expect_out(0)) begin
        n_errors++; $display("FAIL tear_next_t%0d: got %h expected %h", m_t[0], obs(0), expect_out(0));
      end
      if (first_drive0()) begin
        n_checks++;
        if (cd[0] !== 8'hFF) begin
          n_errors++; $display("FAIL tear_new_row%0d: got %h expected ff", ri[0], cd[0]);
        end
      end
    end
  endtask

  task automatic test_collision();
    n_checks++;
    if (fs[0] !== 1'b1) begin
      n_errors++; $display("FAIL collide_in_load: got %b expected 1", fs[0]);
    end
    gv[0] = 1'b1; gi[0] = 64'h0000_0000_0000_00AA;
    tick();
    gv[0] = 1'b0;
    tick();
    n_checks++;
    if ({rs[0], cd[0]} !== {8'hFE, 8'hFF}) begin
      n_errors++; $display("FAIL collide_current: got %h expected feff", {rs[0], cd[0]});
    end
    for (int c = 0; c < 100 && m_t[0] != 0; c++) tick();
    tick(); tick();
    n_checks++;
    if ({rs[0], cd[0]} !== {8'hFE, 8'hAA} || obs(0) !== expect_out(0)) begin
      n_errors++; $display("FAIL collide_next: got %h expected feaa", {rs[0], cd[0]});
    end
  endtask

  task automatic test_enable_drop();
    for (int c = 0; c < 100 && m_t[0] != 27; c++) tick();
    n_checks++;
    if ({rs[0], ri[0]} !== {8'hDF, 3'd5}) begin
      n_errors++; $display("FAIL drop_reach_row5: got %h expected %h", {rs[0], ri[0]}, {8'hDF, 3'd5});
    end
    en[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (obs(0) !== OFF_IDLE) begin
        n_errors++; $display("FAIL drop_idle_c%0d: got %h expected %h", c, obs(0), OFF_IDLE);
      end
    end
    en[0] = 1'b1;
    tick();
    n_checks++;
    if (fs[0] !== 1'b1) begin
      n_errors++; $display("FAIL reenable_frame_start: got %b expected 1", fs[0]);
    end
    tick(); tick();
    n_checks++;
    if ({rs[0], cd[0], ri[0]} !== {8'hFE, 8'hAA, 3'd0}) begin
      n_errors++; $display("FAIL reenable_row0: got %h expected %h", {rs[0], cd[0], ri[0]}, {8'hFE, 8'hAA, 3'd0});
    end
  endtask

  task automatic test_fast_scan();
    gi[1] = {$urandom, $urandom}; gv[1] = 1'b1;
    tick();
    gv[1] = 1'b0; en[1] = 1'b1;
    for (int c = 0; c < 27; c++) begin
      tick();
      n_checks++;
      if (obs(1) !== expect_out(1)) begin
        n_errors++; $display("FAIL fast_model_c%0d: got %h expected %h", c, obs(1), expect_out(1));
      end
      n_checks++;
      if (m_t[1] == 0) begin
        if ({rs[1], fs[1]} !== {8'hFF, 1'b1}) begin
          n_errors++; $display("FAIL fast_load_c%0d: got %h expected %h", c, {rs[1], fs[1]}, {8'hFF, 1'b1});
        end
      end else if (ri[1] !== 3'(m_t[1] - 1) || $countones(~rs[1]) != 1) begin
        n_errors++; $display("FAIL fast_row_c%0d: got idx %0d sel %h expected idx %0d", c, ri[1], rs[1], m_t[1] - 1);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] g;
    g = {$urandom, $urandom};
    g[39:32] = g[39:32] | 8'h10;
    gi[0] = g; gv[0] = 1'b1;
    tick();
    gv[0] = 1'b0;
    for (int c = 0; c < 100 && m_t[0] != 0; c++) tick();
    for (int c = 0; c < 100 && m_t[0] != 23; c++) tick();
    n_checks++;
    if ({ri[0], cd[0]} !== {3'd4, g[39:32]}) begin
      n_errors++; $display("FAIL areset_row4_lit: got %h expected %h", {ri[0], cd[0]}, {3'd4, g[39:32]});
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs(i) !== OFF_IDLE) begin
        n_errors++; $display("FAIL areset_immediate[%0d]: got %h expected %h", i, obs(i), OFF_IDLE);
      end
    end
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 43; c++) begin
      tick();
      n_checks++;
      if (obs(0) !== expect_out(0) || cd[0] !== 8'h00) begin
        n_errors++; $display("FAIL areset_after_c%0d: got %h expected %h", c, obs(0), expect_out(0));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2; i++) begin
        gv[i] = ($urandom_range(0, 9) == 0);
        gi[i] = {$urandom, $urandom};
        if (en[i]) en[i] = ($urandom_range(0, 99) != 0);
        else       en[i] = ($urandom_range(0, 4) == 0);
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs(i) !== expect_out(i) || $countones(~rs[i]) > 1) begin
          n_errors++; $display("FAIL random[%0d]_c%0d: got %h expected %h", i, c, obs(i), expect_out(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_basic();
    test_anti_tearing();
    test_collision();
    test_enable_drop();
    test_fast_scan();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
